// File: rtl/fpu_op_controller_pkg.sv
// Shared types and constants for the FPU operation controller.
// Covers state encoding, op codes, special-value constants and flag bit positions.
package fpu_op_controller_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned FLAG_W = 5;
    localparam int unsigned WDOG_W = 8;

    // Result flag vector is {invalid, divzero, overflow, underflow, inexact}
    localparam int unsigned FLAG_INVALID   = 4;
    localparam int unsigned FLAG_DIVZERO   = 3;
    localparam int unsigned FLAG_OVERFLOW  = 2;
    localparam int unsigned FLAG_UNDERFLOW = 1;
    localparam int unsigned FLAG_INEXACT   = 0;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [DATA_W-1:0] QNAN_SP = 32'h7FC0_0000;
    localparam logic [DATA_W-1:0] QNAN_HP = 32'h0000_7E00;
    localparam logic [DATA_W-1:0] INF_SP  = 32'h7F80_0000;
    localparam logic [DATA_W-1:0] INF_HP  = 32'h0000_7C00;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4
    } state_e;

    typedef struct packed {
        logic sign;
        logic zero;
        logic inf;
        logic nan;
    } fp_class_t;

    typedef struct packed {
        logic              mode_fp;
        logic [1:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } fp_req_t;

    function automatic logic [DATA_W-1:0] qnan_of(input logic mode_fp);
        return mode_fp ? QNAN_SP : QNAN_HP;
    endfunction

    // Infinity with sign placed at bit 31 (single) or bit 15 (half)
    function automatic logic [DATA_W-1:0] inf_of(input logic mode_fp, input logic sign);
        return mode_fp ? (INF_SP | {sign, 31'b0}) : (INF_HP | {16'b0, sign, 15'b0});
    endfunction

endpackage

// File: rtl/fpu_op_controller_decoder.sv
// ieee754_decoder: classifies two operands as zero/inf/NaN with sign.
// Half mode looks only at bits [15:0]; outputs are combinational.
module ieee754_decoder
    import fpu_op_controller_pkg::*;
(
    input  logic              mode_fp_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output fp_class_t         a_cls_c_o,
    output fp_class_t         b_cls_c_o
);

    function automatic fp_class_t classify(input logic mode_fp, input logic [DATA_W-1:0] x);
        fp_class_t c;
        logic      exp_max;
        logic      exp_zero;
        logic      mant_zero;
        if (mode_fp) begin
            exp_max   = &x[30:23];
            exp_zero  = ~|x[30:23];
            mant_zero = ~|x[22:0];
            c.sign    = x[31];
        end else begin
            exp_max   = &x[14:10];
            exp_zero  = ~|x[14:10];
            mant_zero = ~|x[9:0];
            c.sign    = x[15];
        end
        c.zero = exp_zero & mant_zero;
        c.inf  = exp_max & mant_zero;
        c.nan  = exp_max & ~mant_zero;
        return c;
    endfunction

    assign a_cls_c_o = classify(mode_fp_i, a_i);
    assign b_cls_c_o = classify(mode_fp_i, b_i);

endmodule

// File: rtl/fpu_op_controller.sv
// Sequences one FP operation at a time: special cases are resolved locally,
// everything else is handed to the arithmetic core under a watchdog.
module fpu_op_controller
    import fpu_op_controller_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_mode_fp,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              core_start,
    output logic              core_mode_fp,
    output logic [1:0]        core_op,
    output logic [DATA_W-1:0] core_a,
    output logic [DATA_W-1:0] core_b,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_result,
    input  logic [FLAG_W-1:0] core_flags,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [FLAG_W-1:0] res_flags,
    output logic              res_bypass,
    output logic              res_timeout,
    output logic              busy
);

    state_e            state_q, state_d;
    fp_req_t           req_q, req_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [FLAG_W-1:0] res_flags_q, res_flags_d;
    logic              res_bypass_q, res_bypass_d;
    logic              res_timeout_q, res_timeout_d;
    logic              req_ready_q, req_ready_d;
    logic              core_start_q, core_start_d;
    logic              res_valid_q, res_valid_d;
    logic              busy_q, busy_d;

    fp_class_t a_cls, b_cls;
    logic      eff_sub, invalid_c, divzero_c;

    ieee754_decoder u_decoder (
        .mode_fp_i (req_q.mode_fp),
        .a_i       (req_q.a),
        .b_i       (req_q.b),
        .a_cls_c_o (a_cls),
        .b_cls_c_o (b_cls)
    );

    // Special-case classification on the registered operands
    assign eff_sub   = a_cls.sign ^ b_cls.sign ^ (req_q.op == OP_SUB);
    assign invalid_c = a_cls.nan | b_cls.nan
                     | (~req_q.op[1] & a_cls.inf & b_cls.inf & eff_sub)
                     | ((req_q.op == OP_MUL) & ((a_cls.zero & b_cls.inf) | (a_cls.inf & b_cls.zero)))
                     | ((req_q.op == OP_DIV) & ((a_cls.zero & b_cls.zero) | (a_cls.inf & b_cls.inf)));
    assign divzero_c = (req_q.op == OP_DIV) & b_cls.zero & ~a_cls.zero & ~a_cls.inf & ~a_cls.nan;

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        wdog_d        = wdog_q;
        res_data_d    = res_data_q;
        res_flags_d   = res_flags_q;
        res_bypass_d  = res_bypass_q;
        res_timeout_d = res_timeout_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_d   = '{mode_fp: req_mode_fp, op: req_op, a: req_a, b: req_b};
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                res_flags_d   = '0;
                res_timeout_d = 1'b0;
                res_bypass_d  = 1'b0;
                if (invalid_c) begin
                    res_data_d                = qnan_of(req_q.mode_fp);
                    res_flags_d[FLAG_INVALID] = 1'b1;
                    res_bypass_d              = 1'b1;
                    state_d                   = S_OUT;
                end else if (divzero_c) begin
                    res_data_d                = inf_of(req_q.mode_fp, a_cls.sign ^ b_cls.sign);
                    res_flags_d[FLAG_DIVZERO] = 1'b1;
                    res_bypass_d              = 1'b1;
                    state_d                   = S_OUT;
                end else begin
                    state_d = S_START;
                end
            end
            S_START: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wdog_d = wdog_q + 1'b1;
                if (core_done) begin
                    res_data_d  = core_result;
                    res_flags_d = core_flags;
                    state_d     = S_OUT;
                end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
                    res_data_d                = qnan_of(req_q.mode_fp);
                    res_flags_d               = '0;
                    res_flags_d[FLAG_INVALID] = 1'b1;
                    res_timeout_d             = 1'b1;
                    state_d                   = S_OUT;
                end
            end
            S_OUT: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Handshake/status outputs follow the state being entered
        req_ready_d  = (state_d == S_IDLE);
        core_start_d = (state_d == S_START);
        res_valid_d  = (state_d == S_OUT);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            req_q         <= '0;
            wdog_q        <= '0;
            res_data_q    <= '0;
            res_flags_q   <= '0;
            res_bypass_q  <= 1'b0;
            res_timeout_q <= 1'b0;
            req_ready_q   <= 1'b0;
            core_start_q  <= 1'b0;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            wdog_q        <= wdog_d;
            res_data_q    <= res_data_d;
            res_flags_q   <= res_flags_d;
            res_bypass_q  <= res_bypass_d;
            res_timeout_q <= res_timeout_d;
            req_ready_q   <= req_ready_d;
            core_start_q  <= core_start_d;
            res_valid_q   <= res_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign core_start   = core_start_q;
    assign core_mode_fp = req_q.mode_fp;
    assign core_op      = req_q.op;
    assign core_a       = req_q.a;
    assign core_b       = req_q.b;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_flags    = res_flags_q;
    assign res_bypass   = res_bypass_q;
    assign res_timeout  = res_timeout_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_fpu_op_controller.sv
// Scoreboard bench for fpu_op_controller: stimulus pushes expected results,
// a negedge monitor pops and compares on every result handshake.
module tb_fpu_op_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_mode_fp;
    logic [1:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        core_start, core_mode_fp;
    logic [1:0]  core_op;
    logic [31:0] core_a, core_b;
    logic        core_done;
    logic [31:0] core_result;
    logic [4:0]  core_flags;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_flags;
    logic        res_bypass, res_timeout, busy;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  flags;
        logic        bypass;
        logic        timeout;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   start_cnt = 0;

    always #5 clk = ~clk;

    fpu_op_controller #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode_fp(req_mode_fp),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .core_start(core_start), .core_mode_fp(core_mode_fp), .core_op(core_op),
        .core_a(core_a), .core_b(core_b),
        .core_done(core_done), .core_result(core_result), .core_flags(core_flags),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flags(res_flags),
        .res_bypass(res_bypass), .res_timeout(res_timeout), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && core_start) start_cnt++;
    end

    // Result monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", res_data, 32'hxxxx_xxxx);
            end else begin
                e = exp_q.pop_front();
                check("res_data",    res_data,           e.data);
                check("res_flags",   32'(res_flags),     32'(e.flags));
                check("res_bypass",  32'(res_bypass),    32'(e.bypass));
                check("res_timeout", 32'(res_timeout),   32'(e.timeout));
            end
        end
    end

    task automatic issue(input logic mode, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_mode_fp = mode; req_op = op; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (!core_start && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("core_start_seen", 32'(core_start), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("return_to_idle", 32'(req_ready), 32'd1);
    endtask

    // Core-path op: core answers 'dly' cycles after the start pulse
    task automatic core_op_run(input string name, input logic mode, input logic [1:0] op,
                               input logic [31:0] a, input logic [31:0] b, input int dly,
                               input logic [31:0] result, input logic [4:0] flags);
        int s0 = start_cnt;
        exp_q.push_back('{data: result, flags: flags, bypass: 1'b0, timeout: 1'b0});
        issue(mode, op, a, b);
        wait_start();
        repeat (dly) begin @(posedge clk); #1; end
        check({name, "_core_a"}, core_a, a);
        check({name, "_core_b"}, core_b, b);
        check({name, "_core_op"}, 32'({core_mode_fp, core_op}), 32'({mode, op}));
        core_done = 1'b1; core_result = result; core_flags = flags;
        @(posedge clk); #1;
        core_done = 1'b0; core_result = 32'h0; core_flags = 5'h0;
        check({name, "_latency"}, 32'(res_valid), 32'd1);
        wait_idle();
        check({name, "_starts"}, 32'(start_cnt - s0), 32'd1);
    endtask

    // Special-case op: result two cycles after accept, core never started
    task automatic bypass_run(input string name, input logic mode, input logic [1:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] data, input logic [4:0] flags);
        int s0 = start_cnt;
        exp_q.push_back('{data: data, flags: flags, bypass: 1'b1, timeout: 1'b0});
        issue(mode, op, a, b);
        check({name, "_valid_early"}, 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        check({name, "_valid_at_2"}, 32'(res_valid), 32'd1);
        wait_idle();
        check({name, "_starts"}, 32'(start_cnt - s0), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        rst = 1'b1; req_valid = 1'b0; req_mode_fp = 1'b0; req_op = 2'b00;
        req_a = 32'h0; req_b = 32'h0; core_done = 1'b0; core_result = 32'h0;
        core_flags = 5'h0; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res", {res_data[26:0], res_flags}, 32'd0);
        check("rst_misc", 32'({res_valid, core_start, res_bypass, res_timeout}), 32'd0);
        check("rst_core_a", core_a, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(req_ready), 32'd1);

        core_op_run("sp_add", 1'b1, 2'b00, 32'h3F80_0000, 32'h4000_0000, 3, 32'h4040_0000, 5'h00);
        bypass_run("hp_mul_nan", 1'b0, 2'b10, 32'h0000_7E01, 32'h0000_3C00, 32'h0000_7E00, 5'b10000);
        bypass_run("sp_div_zero", 1'b1, 2'b11, 32'hC000_0000, 32'h0000_0000, 32'hFF80_0000, 5'b01000);
        bypass_run("sp_zero_div_zero", 1'b1, 2'b11, 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 5'b10000);
        bypass_run("sp_inf_minus_inf", 1'b1, 2'b00, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 5'b10000);
        bypass_run("sp_zero_mul_inf", 1'b1, 2'b10, 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 5'b10000);
        bypass_run("hp_neg_div_zero", 1'b0, 2'b11, 32'h0000_BC00, 32'h0000_0000, 32'h0000_FC00, 5'b01000);
        core_op_run("sp_inf_plus_inf", 1'b1, 2'b00, 32'h7F80_0000, 32'h7F80_0000, 1, 32'h7F80_0000, 5'h00);

        // Watchdog: one START cycle plus four WAIT cycles, then the abort result
        exp_q.push_back('{data: 32'h7FC0_0000, flags: 5'b10000, bypass: 1'b0, timeout: 1'b1});
        issue(1'b1, 2'b00, 32'h3F80_0000, 32'h4000_0000);
        wait_start();
        repeat (4) begin @(posedge clk); #1; end
        check("timeout_not_yet", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        check("timeout_valid", 32'(res_valid), 32'd1);
        wait_idle();

        // Backpressure with a stray core_done while holding the result
        res_ready = 1'b0;
        exp_q.push_back('{data: 32'h0000_4000, flags: 5'b00001, bypass: 1'b0, timeout: 1'b0});
        issue(1'b0, 2'b00, 32'h0000_3C00, 32'h0000_3C00);
        wait_start();
        @(posedge clk); #1;
        core_done = 1'b1; core_result = 32'h0000_4000; core_flags = 5'b00001;
        @(posedge clk); #1;
        core_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin core_done = 1'b1; core_result = 32'hDEAD_BEEF; core_flags = 5'b11111; end
            if (i == 4) core_done = 1'b0;
            check("stall_data", res_data, 32'h0000_4000);
            check("stall_ctrl", 32'({res_valid, req_ready, res_flags}), 32'({1'b1, 1'b0, 5'b00001}));
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        wait_idle();

        // Reset in WAIT drops the operation silently
        issue(1'b1, 2'b10, 32'h4000_0000, 32'h4040_0000);
        wait_start();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("wrst_status", 32'({req_ready, busy, res_valid, core_start}), 32'd0);
        check("wrst_res", 32'({res_flags, res_bypass, res_timeout}), 32'd0);
        check("wrst_res_data", res_data, 32'd0);
        check("wrst_core_a", core_a, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("wrst_ready", 32'(req_ready), 32'd1);
        core_op_run("sp_sub_after_rst", 1'b1, 2'b01, 32'h4040_0000, 32'h3F80_0000, 2, 32'h4000_0000, 5'h00);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
